game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter FPS, default 60, frames per countdown second.
REQ-002 SHALL have parameter CNT_SECS, default 3, countdown length in seconds.
REQ-003 SHALL have parameter OVER_HOLD, default 120, frames GAMEOVER ignores keys.
REQ-004 SHALL have port frame_clk  input  1  sole clock, one edge per video frame.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port keycode  input  8  current keyboard keycode, 8'h00 = none.
REQ-007 SHALL have port p1_hp  input  8  player-1 health.
REQ-008 SHALL have port p2_hp  input  8  player-2 health.
REQ-009 SHALL have port st  output  1  high in every state except MENU; freezes menu selection.
REQ-010 SHALL have port dual  output  1  two-player mode selected.
REQ-011 SHALL have port single  output  1  one-player mode selected.
REQ-012 SHALL have port sel_y  output  10  menu indicator Y: 276 single, 340 dual.
REQ-013 SHALL have port state  output  3  MENU=0, COUNTDOWN=1, FIGHT=2, PAUSE=3, GAMEOVER=4.
REQ-014 SHALL have port count_digit  output  2  remaining countdown seconds, 0 outside COUNTDOWN.
REQ-015 SHALL have port fight_en  output  1  high only in FIGHT; enables player movement/damage.
REQ-016 SHALL have port winner  output  2  0 none, 1 P1, 2 P2, 3 draw.

Function
REQ-017 SHALL register keycode each frame; a key "press" = keycode != 0 and keycode != previous registered keycode; held keys act once.
REQ-018 SHALL in MENU: press 8'h4B -> single=1, dual=0, sel_y=276; press 8'h4E -> dual=1, single=0, sel_y=340.
REQ-019 SHALL in MENU: press 8'h28 (Enter) -> COUNTDOWN next edge; frame counter=0; count_digit=CNT_SECS.
REQ-020 SHALL ignore 8'h4B/8'h4E outside MENU; dual/single/sel_y hold.
REQ-021 SHALL in COUNTDOWN: frame counter increments each edge; at FPS-1 wraps to 0 and count_digit decrements.
REQ-022 SHALL leave COUNTDOWN for FIGHT on the edge where count_digit would go 1->0; total COUNTDOWN duration exactly CNT_SECS*FPS frames.
REQ-023 SHALL in COUNTDOWN: press 8'h29 (Esc) -> MENU, counters cleared.
REQ-024 SHALL in FIGHT: p1_hp==0 or p2_hp==0 (sampled) -> GAMEOVER next edge, winner latched: p2_hp==0 only ->1; p1_hp==0 only ->2; both 0 ->3.
REQ-025 SHALL in FIGHT: press 8'h29 -> PAUSE; health check has priority over Esc in the same frame.
REQ-026 SHALL in PAUSE: press 8'h29 -> FIGHT; press 8'h28 -> MENU; winner stays 0; fight_en=0.
REQ-027 SHALL in GAMEOVER: hold counter counts OVER_HOLD frames, presses ignored meanwhile; thereafter press 8'h28 -> MENU, winner cleared to 0.
REQ-028 SHALL keep winner stable throughout GAMEOVER.
REQ-029 SHALL treat unused state encodings as MENU on next edge.
REQ-030 SHALL drive all outputs from registers or from state decode only; no keycode-to-output combinational path.

Reset
REQ-031 SHALL on Reset, immediately regardless of state: state=MENU, st=0, single=1, dual=0, sel_y=276, count_digit=0, fight_en=0, winner=0, all counters and previous-keycode register=0.
REQ-032 SHALL resume normal operation on the first frame_clk edge after Reset deasserts.

Verification
REQ-033 SHALL verify reset then keycode 8'h4E for 1 frame -> dual=1, single=0, sel_y=340, st=0; hold 8'h4E 10 frames -> no further change.
REQ-034 SHALL verify Enter press from MENU -> st=1, count_digit 3,2,1 each for 60 frames, fight_en=1 exactly 180 frames after entering COUNTDOWN.
REQ-035 SHALL verify FIGHT with p2_hp=0, p1_hp=50 -> GAMEOVER, winner=1; both hp=0 same frame -> winner=3; Enter within 120 frames ignored, Enter after -> MENU, winner=0.
REQ-036 SHALL verify FIGHT, Esc -> PAUSE, fight_en=0; 8'h4B during PAUSE -> single/dual unchanged; Esc -> FIGHT.
REQ-037 SHALL verify Reset asserted mid-COUNTDOWN (count_digit=2) -> all REQ-031 values immediately, without a clock edge.
REQ-038 SHALL verify Esc and p1_hp=0 in the same FIGHT frame -> GAMEOVER, winner=2, not PAUSE.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game flow controller: menu, countdown, fight, pause and game-over sequencing.
// It is clocked once per video frame. Key presses are edge-detected against the
// keycode registered on the previous frame, so a held key acts only once.
module game_flow_ctrl #(
    parameter int FPS       = 60,
    parameter int CNT_SECS  = 3,
    parameter int OVER_HOLD = 120
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] p1_hp,
    input  logic [7:0] p2_hp,
    output logic       st,
    output logic       dual,
    output logic       single,
    output logic [9:0] sel_y,
    output logic [2:0] state,
    output logic [1:0] count_digit,
    output logic       fight_en,
    output logic [1:0] winner
);

    localparam int FRAME_W = (FPS > 1) ? $clog2(FPS) : 1;
    localparam int HOLD_W  = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

    localparam logic [7:0] KEY_SINGLE = 8'h4B;
    localparam logic [7:0] KEY_DUAL   = 8'h4E;
    localparam logic [7:0] KEY_ENTER  = 8'h28;
    localparam logic [7:0] KEY_ESC    = 8'h29;

    localparam logic [9:0] Y_SINGLE = 10'd276;
    localparam logic [9:0] Y_DUAL   = 10'd340;

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_PAUSE     = 3'd3,
        S_GAMEOVER  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           prev_key_q, prev_key_d;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [1:0]           count_digit_q, count_digit_d;
    logic                 single_q, single_d;
    logic                 dual_q, dual_d;
    logic [9:0]           sel_y_q, sel_y_d;
    logic [1:0]           winner_q, winner_d;
    logic                 st_q, st_d;
    logic                 fight_en_q, fight_en_d;

    logic press_single, press_dual, press_enter, press_esc;

    // Next-state and next-output computation for the whole flow.
    always_comb begin
        press_single = (keycode == KEY_SINGLE) && (keycode != prev_key_q);
        press_dual   = (keycode == KEY_DUAL)   && (keycode != prev_key_q);
        press_enter  = (keycode == KEY_ENTER)  && (keycode != prev_key_q);
        press_esc    = (keycode == KEY_ESC)    && (keycode != prev_key_q);

        state_d       = state_q;
        prev_key_d    = keycode;
        frame_cnt_d   = frame_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        count_digit_d = count_digit_q;
        single_d      = single_q;
        dual_d        = dual_q;
        sel_y_d       = sel_y_q;
        winner_d      = winner_q;

        case (state_q)
            S_MENU: begin
                if (press_single) begin
                    single_d = 1'b1;
                    dual_d   = 1'b0;
                    sel_y_d  = Y_SINGLE;
                end else if (press_dual) begin
                    single_d = 1'b0;
                    dual_d   = 1'b1;
                    sel_y_d  = Y_DUAL;
                end else if (press_enter) begin
                    state_d       = S_COUNTDOWN;
                    frame_cnt_d   = '0;
                    count_digit_d = 2'(CNT_SECS);
                end
            end
            S_COUNTDOWN: begin
                if (press_esc) begin
                    state_d       = S_MENU;
                    frame_cnt_d   = '0;
                    count_digit_d = '0;
                end else if (frame_cnt_q == FRAME_W'(FPS - 1)) begin
                    frame_cnt_d = '0;
                    if (count_digit_q <= 2'd1) begin
                        state_d       = S_FIGHT;
                        count_digit_d = '0;
                    end else begin
                        count_digit_d = count_digit_q - 2'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            S_FIGHT: begin
                if ((p1_hp == 8'd0) || (p2_hp == 8'd0)) begin
                    state_d    = S_GAMEOVER;
                    hold_cnt_d = '0;
                    winner_d   = {p1_hp == 8'd0, p2_hp == 8'd0};
                end else if (press_esc) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (press_esc) begin
                    state_d = S_FIGHT;
                end else if (press_enter) begin
                    state_d = S_MENU;
                end
            end
            S_GAMEOVER: begin
                if (hold_cnt_q < HOLD_W'(OVER_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (press_enter) begin
                    state_d    = S_MENU;
                    hold_cnt_d = '0;
                    winner_d   = 2'd0;
                end
            end
            default: begin
                state_d       = S_MENU;
                frame_cnt_d   = '0;
                hold_cnt_d    = '0;
                count_digit_d = '0;
                winner_d      = 2'd0;
            end
        endcase

        st_d       = (state_d != S_MENU);
        fight_en_d = (state_d == S_FIGHT);
    end

    // State and output registers, cleared asynchronously by Reset.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_MENU;
            prev_key_q    <= 8'd0;
            frame_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            count_digit_q <= 2'd0;
            single_q      <= 1'b1;
            dual_q        <= 1'b0;
            sel_y_q       <= Y_SINGLE;
            winner_q      <= 2'd0;
            st_q          <= 1'b0;
            fight_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_key_q    <= prev_key_d;
            frame_cnt_q   <= frame_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            count_digit_q <= count_digit_d;
            single_q      <= single_d;
            dual_q        <= dual_d;
            sel_y_q       <= sel_y_d;
            winner_q      <= winner_d;
            st_q          <= st_d;
            fight_en_q    <= fight_en_d;
        end
    end

    assign state       = state_q;
    assign st          = st_q;
    assign dual        = dual_q;
    assign single      = single_q;
    assign sel_y       = sel_y_q;
    assign count_digit = count_digit_q;
    assign fight_en    = fight_en_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed testbench for game_flow_ctrl using hand-computed expectations.
module tb_game_flow_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [7:0] p1_hp = 8'd100;
    logic [7:0] p2_hp = 8'd100;
    logic       st, dual, single, fight_en;
    logic [9:0] sel_y;
    logic [2:0] state;
    logic [1:0] count_digit, winner;

    int n_checks = 0;
    int n_fails  = 0;

    game_flow_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .p1_hp       (p1_hp),
        .p2_hp       (p2_hp),
        .st          (st),
        .dual        (dual),
        .single      (single),
        .sel_y       (sel_y),
        .state       (state),
        .count_digit (count_digit),
        .fight_en    (fight_en),
        .winner      (winner)
    );

    // Free-running frame clock, rising edges at 5, 15, 25, ...
    always #5 frame_clk = ~frame_clk;

    // Advance one frame and settle just after the rising edge.
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Drive a keycode and let one frame elapse.
    task automatic applyStimulus(input logic [7:0] key);
        keycode = key;
        tick();
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Every output must hold its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"},  32'(state), 32'd0);
        checkOutput({tag, "_st"},     32'(st), 32'd0);
        checkOutput({tag, "_single"}, 32'(single), 32'd1);
        checkOutput({tag, "_dual"},   32'(dual), 32'd0);
        checkOutput({tag, "_sel_y"},  32'(sel_y), 32'd276);
        checkOutput({tag, "_digit"},  32'(count_digit), 32'd0);
        checkOutput({tag, "_fight"},  32'(fight_en), 32'd0);
        checkOutput({tag, "_winner"}, 32'(winner), 32'd0);
    endtask

    // Press Enter from MENU, then run the full countdown into FIGHT.
    task automatic runCountdownToFight(input string tag);
        applyStimulus(8'h28);
        checkOutput({tag, "_cd_state"}, 32'(state), 32'd1);
        keycode = 8'h00;
        repeat (180) tick();
        checkOutput({tag, "_fight_state"}, 32'(state), 32'd2);
        checkOutput({tag, "_fight_en"}, 32'(fight_en), 32'd1);
    endtask

    initial begin
        // Reset before any clock edge.
        #1 Reset = 1'b1;
        #2;
        checkResetValues("reset_init");
        tick();
        tick();
        Reset = 1'b0;

        // Dual selection, then holding the key changes nothing.
        applyStimulus(8'h4E);
        checkOutput("sel_dual", 32'(dual), 32'd1);
        checkOutput("sel_single", 32'(single), 32'd0);
        checkOutput("sel_y_dual", 32'(sel_y), 32'd340);
        checkOutput("sel_st", 32'(st), 32'd0);
        repeat (10) tick();
        checkOutput("hold_dual", 32'(dual), 32'd1);
        checkOutput("hold_sel_y", 32'(sel_y), 32'd340);
        checkOutput("hold_state", 32'(state), 32'd0);

        // Enter starts a 3-second countdown; FIGHT begins 180 frames later.
        applyStimulus(8'h00);
        applyStimulus(8'h28);
        checkOutput("cd_st", 32'(st), 32'd1);
        checkOutput("cd_digit0", 32'(count_digit), 32'd3);
        keycode = 8'h00;
        for (int i = 1; i <= 180; i++) begin
            tick();
            checkOutput($sformatf("cd_state_%0d", i), 32'(state), (i == 180) ? 32'd2 : 32'd1);
            checkOutput($sformatf("cd_digit_%0d", i), 32'(count_digit), (i == 180) ? 32'd0 : 32'(3 - i / 60));
            checkOutput($sformatf("cd_fight_%0d", i), 32'(fight_en), (i == 180) ? 32'd1 : 32'd0);
        end

        // Pause and resume; mode keys are ignored while paused.
        applyStimulus(8'h29);
        checkOutput("pause_state", 32'(state), 32'd3);
        checkOutput("pause_fight", 32'(fight_en), 32'd0);
        checkOutput("pause_st", 32'(st), 32'd1);
        applyStimulus(8'h4B);
        checkOutput("pause_single", 32'(single), 32'd0);
        checkOutput("pause_dual", 32'(dual), 32'd1);
        checkOutput("pause_state2", 32'(state), 32'd3);
        applyStimulus(8'h29);
        checkOutput("resume_state", 32'(state), 32'd2);
        checkOutput("resume_fight", 32'(fight_en), 32'd1);
        checkOutput("resume_winner", 32'(winner), 32'd0);

        // Player 2 knocked out: P1 wins; Enter ignored during the hold period.
        p1_hp = 8'd50;
        p2_hp = 8'd0;
        applyStimulus(8'h00);
        checkOutput("ko_state", 32'(state), 32'd4);
        checkOutput("ko_winner", 32'(winner), 32'd1);
        checkOutput("ko_fight", 32'(fight_en), 32'd0);
        p1_hp = 8'd100;
        p2_hp = 8'd100;
        applyStimulus(8'h28);
        checkOutput("hold_enter_early", 32'(state), 32'd4);
        keycode = 8'h00;
        for (int k = 2; k <= 119; k++) begin
            tick();
            checkOutput($sformatf("hold_winner_%0d", k), 32'(winner), 32'd1);
        end
        applyStimulus(8'h28);
        checkOutput("hold_enter_last", 32'(state), 32'd4);
        applyStimulus(8'h00);
        checkOutput("hold_done_state", 32'(state), 32'd4);
        applyStimulus(8'h28);
        checkOutput("over_exit_state", 32'(state), 32'd0);
        checkOutput("over_exit_winner", 32'(winner), 32'd0);
        checkOutput("over_exit_st", 32'(st), 32'd0);

        // Both players knocked out in the same frame: draw, held stable.
        applyStimulus(8'h00);
        runCountdownToFight("draw");
        p1_hp = 8'd0;
        p2_hp = 8'd0;
        tick();
        checkOutput("draw_state", 32'(state), 32'd4);
        checkOutput("draw_winner", 32'(winner), 32'd3);
        repeat (5) tick();
        checkOutput("draw_winner_hold", 32'(winner), 32'd3);
        p1_hp = 8'd100;
        p2_hp = 8'd100;

        // Leave GAMEOVER via reset, then Esc aborts a countdown.
        Reset = 1'b1;
        #2;
        checkResetValues("reset_over");
        tick();
        Reset = 1'b0;
        applyStimulus(8'h28);
        checkOutput("esc_cd_state", 32'(state), 32'd1);
        keycode = 8'h00;
        repeat (5) tick();
        applyStimulus(8'h29);
        checkOutput("esc_cd_menu", 32'(state), 32'd0);
        checkOutput("esc_cd_digit", 32'(count_digit), 32'd0);
        checkOutput("esc_cd_st", 32'(st), 32'd0);

        // Asynchronous reset mid-countdown while showing digit 2.
        applyStimulus(8'h4E);
        applyStimulus(8'h28);
        keycode = 8'h00;
        repeat (70) tick();
        checkOutput("mid_cd_digit", 32'(count_digit), 32'd2);
        checkOutput("mid_cd_dual", 32'(dual), 32'd1);
        Reset = 1'b1;
        #2;
        checkResetValues("reset_mid_cd");
        tick();
        Reset = 1'b0;

        // Esc and P1 knockout in the same frame: knockout wins.
        runCountdownToFight("esc_ko");
        p1_hp = 8'd0;
        applyStimulus(8'h29);
        checkOutput("esc_ko_state", 32'(state), 32'd4);
        checkOutput("esc_ko_winner", 32'(winner), 32'd2);
        checkOutput("esc_ko_fight", 32'(fight_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
